gpu_host_ctrl: RTL and testbench

- Host-side boot/readback controller placed beside the System top, between the off-chip host stream and the SMCore, InstructionMemory and DataMemory.
- Holds the SMCore in reset while it streams a program into instruction memory and initial data into data memory.
- Releases the core, waits for the core-done indication (CU reaches STATE_END), then streams every data-memory word back to the host.
- Replaces the bench-side $fopen memory dump with synthesizable hardware.

---
 rtl/gpu_host_pkg.sv | 26 ++
 rtl/gpu_host_ctrl_if.sv | 51 +++++
 rtl/hostctrl_watchdog.sv | 26 ++
 rtl/gpu_host_ctrl.sv | 160 ++++++++++++++++
 tb/tb_gpu_host_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/gpu_host_pkg.sv
// Shared types and defaults for the host boot/readback controller.
// STATE_END_CODE is the CU state the System wrapper compares against to produce core_done.
package gpu_host_pkg;

  localparam int IW_DEF             = 32;
  localparam int DW_DEF             = 16;
  localparam int IMEM_DEPTH_DEF     = 256;
  localparam int DMEM_DEPTH_DEF     = 32;
  localparam int MAX_RUN_CYCLES_DEF = 65535;
  localparam int STATE_END_CODE     = 19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_PROG,
    ST_LOAD_DATA,
    ST_RUN,
    ST_DUMP_RD,
    ST_DUMP_OUT,
    ST_DONE
  } state_t;

  function automatic logic is_busy(input state_t s);
    return !(s == ST_IDLE || s == ST_DONE);
  endfunction

endpackage

// File: rtl/gpu_host_ctrl_if.sv
// Host stream, memory write/read, core control and dump stream bundle for gpu_host_ctrl.
// err_timeout exists only when GPU_HOST_WATCHDOG_EN is defined.
interface gpu_host_ctrl_if
  import gpu_host_pkg::*;
#(
  parameter int IW      = IW_DEF,
  parameter int DW      = DW_DEF,
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [IW-1:0]      in_data;
  logic               in_last;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [IW-1:0]      imem_wdata;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [DW-1:0]      dmem_wdata;
  logic [DW-1:0]      dmem_rdata;
  logic               core_reset;
  logic               core_done;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic               busy;
  logic               err_ovf;
`ifdef GPU_HOST_WATCHDOG_EN
  logic               err_timeout;
`endif

  modport master (
    input  in_valid, in_data, in_last, dmem_rdata, core_done, out_ready,
    output in_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata,
           core_reset, out_valid, out_data, busy, err_ovf
`ifdef GPU_HOST_WATCHDOG_EN
    , output err_timeout
`endif
  );

  modport slave (
    output in_valid, in_data, in_last, dmem_rdata, core_done, out_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata,
           core_reset, out_valid, out_data, busy, err_ovf
`ifdef GPU_HOST_WATCHDOG_EN
    , input err_timeout
`endif
  );

endinterface

// File: rtl/hostctrl_watchdog.sv
// RUN-phase cycle counter; expired is high in the MAX_CYCLES-th consecutive cycle of run.
// Zero latency on expired, no backpressure; present only with GPU_HOST_WATCHDOG_EN.
`ifdef GPU_HOST_WATCHDOG_EN
module hostctrl_watchdog #(
  parameter int MAX_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = run ? (cnt_q + 1'b1) : '0;
    expired = run && (cnt_q == CW'(MAX_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule
`endif

// File: rtl/gpu_host_ctrl.sv
// Boot/readback controller: loads IMEM/DMEM, runs the core, streams DMEM back; writes are same-cycle,
// dump is 2 cycles/word and out_data holds under out_ready=0. Optional watchdog: GPU_HOST_WATCHDOG_EN.
module gpu_host_ctrl
  import gpu_host_pkg::*;
#(
  parameter int IW         = IW_DEF,
  parameter int DW         = DW_DEF,
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int DMEM_DEPTH = DMEM_DEPTH_DEF
`ifdef GPU_HOST_WATCHDOG_EN
  , parameter int MAX_RUN_CYCLES = MAX_RUN_CYCLES_DEF
`endif
) (
  input logic            clk,
  input logic            reset,
  input logic            start,
  gpu_host_ctrl_if.master host
);
  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);
  localparam logic [IMEM_AW-1:0] PCNT_LAST = IMEM_AW'(IMEM_DEPTH - 1);
  localparam logic [DMEM_AW-1:0] DCNT_LAST = DMEM_AW'(DMEM_DEPTH - 1);

  state_t             state_q, state_d;
  logic [IMEM_AW-1:0] pcnt_q, pcnt_d;
  logic [DMEM_AW-1:0] dcnt_q, dcnt_d;
  logic [DMEM_AW-1:0] rcnt_q, rcnt_d;
  logic               err_ovf_q, err_ovf_d;
  logic [DW-1:0]      out_data_q, out_data_d;
  logic               run_first_q, run_first_d;
  logic [IW-1:0]      in_word;

  assign in_word = host.in_data;

`ifdef GPU_HOST_WATCHDOG_EN
  logic err_timeout_q, err_timeout_d;
  logic wd_expired;

  hostctrl_watchdog #(.MAX_CYCLES(MAX_RUN_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .run     (state_q == ST_RUN),
    .expired (wd_expired)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pcnt_q      <= '0;
      dcnt_q      <= '0;
      rcnt_q      <= '0;
      err_ovf_q   <= 1'b0;
      out_data_q  <= '0;
      run_first_q <= 1'b0;
`ifdef GPU_HOST_WATCHDOG_EN
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      dcnt_q      <= dcnt_d;
      rcnt_q      <= rcnt_d;
      err_ovf_q   <= err_ovf_d;
      out_data_q  <= out_data_d;
      run_first_q <= run_first_d;
`ifdef GPU_HOST_WATCHDOG_EN
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    dcnt_d      = dcnt_q;
    rcnt_d      = rcnt_q;
    err_ovf_d   = err_ovf_q;
    out_data_d  = (state_q == ST_DUMP_RD) ? host.dmem_rdata : out_data_q;
    run_first_d = (state_q != ST_RUN);
`ifdef GPU_HOST_WATCHDOG_EN
    err_timeout_d = err_timeout_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_LOAD_PROG;
          pcnt_d    = '0;
          dcnt_d    = '0;
          rcnt_d    = '0;
          err_ovf_d = 1'b0;
`ifdef GPU_HOST_WATCHDOG_EN
          err_timeout_d = 1'b0;
`endif
        end
      end
      ST_LOAD_PROG: begin
        if (host.in_valid) begin
          // The last IMEM slot never wraps: a missing in_last there is an overflow.
          if (pcnt_q != PCNT_LAST) pcnt_d = pcnt_q + 1'b1;
          if (host.in_last) begin
            state_d = ST_LOAD_DATA;
          end else if (pcnt_q == PCNT_LAST) begin
            err_ovf_d = 1'b1;
            state_d   = ST_LOAD_DATA;
          end
        end
      end
      ST_LOAD_DATA: begin
        if (host.in_valid) begin
          if (dcnt_q == DCNT_LAST) state_d = ST_RUN;
          else                     dcnt_d  = dcnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!run_first_q && host.core_done) begin
          state_d = ST_DUMP_RD;
        end
`ifdef GPU_HOST_WATCHDOG_EN
        else if (wd_expired) begin
          err_timeout_d = 1'b1;
          state_d       = ST_DUMP_RD;
        end
`endif
      end
      ST_DUMP_RD: state_d = ST_DUMP_OUT;
      ST_DUMP_OUT: begin
        if (host.out_ready) begin
          if (rcnt_q == DCNT_LAST) begin
            state_d = ST_DONE;
          end else begin
            rcnt_d  = rcnt_q + 1'b1;
            state_d = ST_DUMP_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    host.in_ready   = (state_q == ST_LOAD_PROG) || (state_q == ST_LOAD_DATA);
    host.imem_we    = (state_q == ST_LOAD_PROG) && host.in_valid;
    host.imem_addr  = pcnt_q;
    host.imem_wdata = in_word;
    host.dmem_we    = (state_q == ST_LOAD_DATA) && host.in_valid;
    // Read address runs one step ahead so a synchronous DMEM has the word ready by DUMP_OUT entry.
    host.dmem_addr  = (state_q == ST_LOAD_DATA) ? dcnt_q : rcnt_d;
    host.dmem_wdata = in_word[DW-1:0];
    host.core_reset = (state_q != ST_RUN);
    host.out_valid  = (state_q == ST_DUMP_OUT);
    host.out_data   = out_data_q;
    host.busy       = is_busy(state_q);
    host.err_ovf    = err_ovf_q;
`ifdef GPU_HOST_WATCHDOG_EN
    host.err_timeout = err_timeout_q;
`endif
  end

endmodule

// File: tb/tb_gpu_host_ctrl.sv
// Randomized bench for gpu_host_ctrl against a queue-based reference of load, run and dump behaviour.
// Bench-owned synchronous IMEM/DMEM models and a stubbed core_done.
module tb_gpu_host_ctrl;
  localparam int IMEM_DEPTH = 256;
  localparam int DMEM_DEPTH = 32;

  logic clk = 1'b0;
  logic reset;
  logic start;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  gpu_host_ctrl_if #(.IW(32), .DW(16), .IMEM_AW(8), .DMEM_AW(5)) bus ();

  gpu_host_ctrl #(.IW(32), .DW(16), .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .host  (bus)
  );

  logic [31:0] imem [IMEM_DEPTH];
  logic [15:0] dmem [DMEM_DEPTH];
  logic [31:0] exp_imem [IMEM_DEPTH];

  always @(posedge clk) begin
    if (bus.imem_we) imem[bus.imem_addr] <= bus.imem_wdata;
    if (bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
    bus.dmem_rdata <= dmem[bus.dmem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("busy_after_start", bus.busy, 1'b1);
    chk("ovf_clear_on_start", bus.err_ovf, 1'b0);
  endtask

  // One full load/run/dump. rdy_mode: 0 always ready, 1 random, 2 stall 5 cycles on word 7.
  task automatic run_seq(input int nprog, input bit last_on_end, input bit seq_data,
                         input int rdy_mode, input int vld_pct, input int done_dly);
    logic [31:0] stream [$];
    logic        lasts  [$];
    logic [31:0] prog   [$];
    logic [15:0] dat    [$];
    logic [15:0] got    [$];
    int acc, ncyc, hs_prev, nhs, stall;
    bit exp_ovf, rdy, pv, pr;
    logic [15:0] pd;

    for (int i = 0; i < nprog; i++) begin
      prog.push_back($urandom);
      stream.push_back(prog[i]);
      lasts.push_back(last_on_end && (i == nprog - 1));
    end
    for (int i = 0; i < DMEM_DEPTH; i++) begin
      dat.push_back(seq_data ? 16'(i) : 16'($urandom));
      stream.push_back({16'($urandom), dat[i]});
      lasts.push_back(1'($urandom_range(1)));
    end
    exp_ovf = (nprog == IMEM_DEPTH) && !last_on_end;

    pulse_start();
    acc = 0;
    ncyc = 0;
    while (acc < stream.size() && ncyc < 5000) begin
      bus.in_valid  = ($urandom_range(99) < vld_pct);
      bus.in_data   = stream[acc];
      bus.in_last   = lasts[acc];
      bus.core_done = 1'($urandom_range(1));
      #1;
      chk("in_ready_load", bus.in_ready, 1'b1);
      chk("core_reset_load", bus.core_reset, 1'b1);
      chk("we_exclusive", bus.imem_we & bus.dmem_we, 1'b0);
      if (bus.in_valid) acc++;
      @(negedge clk);
      ncyc++;
    end
    chk("feed_accepts", acc, stream.size());
    bus.in_valid  = 1'b0;
    bus.core_done = 1'b1;
    #1;
    chk("core_reset_fall", bus.core_reset, 1'b0);
    chk("in_ready_run", bus.in_ready, 1'b0);
    chk("busy_run", bus.busy, 1'b1);
    @(negedge clk);
    bus.core_done = 1'b0;
    #1;
    chk("first_run_done_ignored", bus.core_reset, 1'b0);
    for (int d = 0; d < done_dly; d++) begin
      @(negedge clk);
      start = 1'($urandom_range(1));
      #1;
      chk("run_hold", bus.core_reset, 1'b0);
    end
    @(negedge clk);
    start = 1'b0;
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
    #1;
    chk("core_reset_dump", bus.core_reset, 1'b1);
    chk("out_valid_dump_rd", bus.out_valid, 1'b0);

    nhs = 0; ncyc = 0; hs_prev = -1; stall = 0;
    pv = 1'b0; pr = 1'b0; pd = '0;
    while (nhs < DMEM_DEPTH && ncyc < 2000) begin
      if (pv && !pr) begin
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_data", bus.out_data, pd);
      end
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(1));
        default: rdy = !(nhs == 7 && bus.out_valid && stall < 5);
      endcase
      if (rdy_mode == 2 && nhs == 7 && bus.out_valid && !rdy) stall++;
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) begin
        got.push_back(bus.out_data);
        if (rdy_mode == 0 && hs_prev >= 0) chk("dump_spacing", ncyc - hs_prev, 2);
        hs_prev = ncyc;
        nhs++;
      end
      pv = bus.out_valid;
      pr = rdy;
      pd = bus.out_data;
      @(negedge clk);
      ncyc++;
    end
    bus.out_ready = 1'b0;
    #1;
    chk("dump_count", got.size(), DMEM_DEPTH);
    chk("busy_done", bus.busy, 1'b0);
    chk("out_valid_done", bus.out_valid, 1'b0);
    chk("err_ovf", bus.err_ovf, exp_ovf);
    if (rdy_mode == 2) chk("stall_cycles", stall, 5);
    for (int i = 0; i < DMEM_DEPTH; i++) begin
      chk("dmem_image", dmem[i], dat[i]);
      if (i < got.size()) chk("dump_word", got[i], dat[i]);
    end
    for (int i = 0; i < nprog; i++) exp_imem[i] = prog[i];
    for (int i = 0; i <= nprog && i < IMEM_DEPTH; i++) chk("imem_image", imem[i], exp_imem[i]);
  endtask

  task automatic reset_mid_load();
    int acc;
    pulse_start();
    acc = 0;
    while (acc < 4 + 10) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      bus.in_last  = (acc == 3);
      if (acc < 4) exp_imem[acc] = bus.in_data;
      #1;
      acc++;
      @(negedge clk);
    end
    reset = 1'b1;
    bus.in_data = $urandom;
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_mid_in_ready", bus.in_ready, 1'b0);
    chk("rst_mid_core_reset", bus.core_reset, 1'b1);
    chk("rst_mid_busy", bus.busy, 1'b0);
    chk("rst_mid_dmem_we", bus.dmem_we, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.core_done = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_core_reset", bus.core_reset, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_err_ovf", bus.err_ovf, 1'b0);
    chk("rst_imem_we", bus.imem_we, 1'b0);
    chk("rst_dmem_we", bus.dmem_we, 1'b0);
    chk("rst_imem_addr", bus.imem_addr, 8'd0);
    chk("rst_dmem_addr", bus.dmem_addr, 5'd0);
    chk("rst_out_data", bus.out_data, 16'd0);
    reset = 1'b0;

    run_seq(4, 1'b1, 1'b1, 0, 100, 50);
    run_seq(4, 1'b1, 1'b1, 2, 100, 10);
    run_seq(256, 1'b0, 1'b0, 1, 80, 5);
    run_seq(256, 1'b1, 1'b0, 0, 90, 3);
    reset_mid_load();
    repeat (4) run_seq($urandom_range(1, 20), 1'b1, 1'b0, 1, 70, $urandom_range(0, 30));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
